// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle between an ALU client and seq_alu
// Purpose: groups the start/operand request and the done/result/flags response.
// Signals: start, opA, opB, opcode (client to ALU); ready, done, result, carry,
//          overflow, zero (ALU to client).
// Modports: master = client side, slave = ALU side.
interface seq_alu_if #(
  parameter int d_Width = 8
);
  logic               start;
  logic [d_Width-1:0] opA;
  logic [d_Width-1:0] opB;
  logic [2:0]         opcode;
  logic               ready;
  logic               done;
  logic [d_Width-1:0] result;
  logic               carry;
  logic               overflow;
  logic               zero;

  modport master (
    output start, opA, opB, opcode,
    input  ready, done, result, carry, overflow, zero
  );

  modport slave (
    input  start, opA, opB, opcode,
    output ready, done, result, carry, overflow, zero
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with an iterative one-bit-per-cycle shifter
// Purpose: accepts an operation while ready, executes add/sub/logic in one cycle,
//          shifts one bit per cycle, then pulses done with registered result/flags.
// Ports: clk  - rising-edge clock
//        rst  - asynchronous active-high reset
//        bus  - seq_alu_if.slave (start/opA/opB/opcode in; ready/done/result/
//               carry/overflow/zero out)
// Build option: ALU_ROTATE_EN makes opcode 111 rotate-left by (opB mod d_Width);
//               without it opcode 111 returns zero.
module seq_alu #(
  parameter int d_Width = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(d_Width + 1);
  localparam logic [d_Width-1:0] W_VAL   = d_Width'(d_Width);
  localparam logic [CW-1:0]      CNT_MAX = CW'(d_Width);

`ifdef ALU_ROTATE_EN
  localparam bit rot_en = 1'b1;
`else
  localparam bit rot_en = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ROT = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t             state, state_n;
  logic [d_Width-1:0] a_q, b_q, work, result_q;
  logic [2:0]         op_q;
  logic [CW-1:0]      cnt;
  logic               shout, carry_q, ovf_q, zero_q;
  logic               ready_c, done_c;

  logic [d_Width:0]   sum, diff;
  logic [d_Width-1:0] exec_res;
  logic               exec_c, exec_v, is_shift, is_rot;

  // Single-cycle datapath; evaluated from the latched operands in EXEC.
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    is_rot   = rot_en && (op_q == OP_ROT);
    is_shift = (op_q == OP_SHL) || (op_q == OP_SHR) || is_rot;
    case (op_q)
      OP_ADD: begin
        exec_res = sum[d_Width-1:0];
        exec_c   = sum[d_Width];
        exec_v   = (a_q[d_Width-1] == b_q[d_Width-1]) && (sum[d_Width-1] != a_q[d_Width-1]);
      end
      OP_SUB: begin
        exec_res = diff[d_Width-1:0];
        exec_c   = diff[d_Width];  // wraps to 1 exactly when A < B unsigned
        exec_v   = (a_q[d_Width-1] != b_q[d_Width-1]) && (diff[d_Width-1] != a_q[d_Width-1]);
      end
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready_c = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_n = EXEC;
      end
      EXEC:  state_n = is_shift ? SHIFT : DONE;
      SHIFT: if (cnt == '0) state_n = DONE;
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      work     <= '0;
      cnt      <= '0;
      shout    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q  <= bus.opA;
          b_q  <= bus.opB;
          op_q <= bus.opcode;
        end
        EXEC: if (is_shift) begin
          work  <= a_q;
          shout <= 1'b0;
          if (is_rot)             cnt <= CW'(b_q % W_VAL);
          else if (b_q >= W_VAL)  cnt <= CNT_MAX;  // shifting past the width just empties the word
          else                    cnt <= CW'(b_q);
        end else begin
          result_q <= exec_res;
          carry_q  <= exec_c;
          ovf_q    <= exec_v;
          zero_q   <= (exec_res == '0);
        end
        SHIFT: if (cnt == '0) begin
          result_q <= work;
          carry_q  <= shout;
          ovf_q    <= 1'b0;
          zero_q   <= (work == '0);
        end else begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_SHR) begin
            work  <= {1'b0, work[d_Width-1:1]};
            shout <= work[0];
          end else begin
            // Rotate feeds the outgoing MSB back into the LSB; plain shl zero-fills.
            work  <= {work[d_Width-2:0], is_rot ? work[d_Width-1] : 1'b0};
            shout <= work[d_Width-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = ready_c;
  assign bus.done     = done_c;
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu with a cycle-level reference model
module tb_seq_alu;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst;

  seq_alu_if #(.d_Width(W)) bus ();
  seq_alu #(.d_Width(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int to_s(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic bit out_of_range(input int s);
    return (s > M / 2 - 1) || (s < -(M / 2));
  endfunction

  // Architectural result of one operation plus its capture-to-done latency in edges.
  function automatic void ref_op(input int a, input int b, input int op,
                                 output int res, output int c, output int v, output int lat);
    int n;
    int s;
    res = 0; c = 0; v = 0; lat = 1;
    case (op)
      0: begin s = a + b; res = s % M; c = int'(s >= M); v = int'(out_of_range(to_s(a) + to_s(b))); end
      1: begin res = (a - b + M) % M; c = int'(a < b); v = int'(out_of_range(to_s(a) - to_s(b))); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin
        n = (b > W) ? W : b;
        res = (a << n) % M;
        c = (n == 0) ? 0 : ((a >> (W - n)) & 1);
        lat = 2 + n;
      end
      6: begin
        n = (b > W) ? W : b;
        res = a >> n;
        c = (n == 0) ? 0 : ((a >> (n - 1)) & 1);
        lat = 2 + n;
      end
      default: begin
`ifdef ALU_ROTATE_EN
        n = b % W;
        res = ((a << n) | (a >> (W - n))) % M;
        c = (n == 0) ? 0 : (res & 1);
        lat = 2 + n;
`endif
      end
    endcase
  endfunction

  int edge_cnt = 0;
  int m_done_edge = 0;
  bit m_busy = 1'b0;
  int m_res = 0, m_c = 0, m_v = 0, m_z = 0;
  int p_res = 0, p_c = 0, p_v = 0, p_lat = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_res = 0; m_c = 0; m_v = 0; m_z = 0;
    end else begin
      edge_cnt++;
      if (!m_busy) begin
        if (bus.start === 1'b1) begin
          ref_op(int'(bus.opA), int'(bus.opB), int'(bus.opcode), p_res, p_c, p_v, p_lat);
          m_busy = 1'b1;
          m_done_edge = edge_cnt + p_lat;
        end
      end else if (edge_cnt == m_done_edge) begin
        m_res = p_res; m_c = p_c; m_v = p_v; m_z = int'(p_res == 0);
      end else if (edge_cnt == m_done_edge + 1) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("cyc_ready", bus.ready, !m_busy);
      check("cyc_done", bus.done, m_busy && (edge_cnt == m_done_edge));
      check("cyc_result", bus.result, m_res);
      check("cyc_carry", bus.carry, m_c);
      check("cyc_overflow", bus.overflow, m_v);
      check("cyc_zero", bus.zero, m_z);
    end
  end

  task automatic run_op(input string nm, input int a, input int b, input int op,
                        input int er, input int ec, input int ev, input int ez, input int el);
    int k;
    bit seen;
    @(negedge clk);
    bus.opA = W'(a); bus.opB = W'(b); bus.opcode = 3'(op); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({nm, "_lat"}, seen ? k : 99, el);
    check({nm, "_res"}, bus.result, er);
    check({nm, "_carry"}, bus.carry, ec);
    check({nm, "_ovf"}, bus.overflow, ev);
    check({nm, "_zero"}, bus.zero, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn;
    rst = 1'b1;
    bus.start = 1'b0; bus.opA = '0; bus.opB = '0; bus.opcode = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 0);
    rst = 1'b0;

    run_op("add",     'hAA, 'hBB, 0, 'h65, 1, 1, 0, 1);
    run_op("sub",     'hAA, 'hBB, 1, 'hEF, 1, 0, 0, 1);
    run_op("xor",     'hAA, 'hAA, 4, 'h00, 0, 0, 1, 1);
    run_op("and",     'hF0, 'h3C, 2, 'h30, 0, 0, 0, 1);
    run_op("or",      'h0F, 'h30, 3, 'h3F, 0, 0, 0, 1);
    run_op("add_ovf", 'h7F, 'h01, 0, 'h80, 0, 1, 0, 1);
    run_op("shl3",    'h31, 'h03, 5, 'h88, 1, 0, 0, 5);
    run_op("shl0",    'h5A, 'h00, 5, 'h5A, 0, 0, 0, 2);
    run_op("shr9",    'hFF, 'h09, 6, 'h00, 1, 0, 1, 10);
`ifdef ALU_ROTATE_EN
    run_op("rot9",    'h81, 'h09, 7, 'h03, 1, 0, 0, 3);
`else
    run_op("op7",     'hAA, 'h55, 7, 'h00, 0, 0, 1, 1);
`endif

    // start held high with operands changing every cycle
    dn = 0;
    @(negedge clk);
    bus.opA = 8'h12; bus.opB = 8'h34; bus.opcode = 3'd0; bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      bus.opA = W'(i * 37 + 5);
      bus.opB = W'(i * 11 + 3);
      bus.opcode = 3'(i % 5);
    end
    bus.start = 1'b0;
    check("b2b_dones", dn, 10);

    run_op("add_pre", 'h10, 'h20, 0, 'h30, 0, 0, 0, 1);

    // reset while a shift is in progress
    @(negedge clk);
    bus.opA = 8'h01; bus.opB = 8'h07; bus.opcode = 3'd5; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", bus.ready, 1);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_carry", bus.carry, 0);
    check("midrst_ovf", bus.overflow, 0);
    check("midrst_zero", bus.zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("midrst_no_done", dn, 0);

    run_op("add_post", 'h01, 'hFF, 0, 'h00, 1, 0, 1, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
